// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the instruction-memory loader.
// Memory geometry and the loader FSM state encoding live here.
package imem_loader_pkg;

    localparam int IMEM_DEPTH     = 64;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        FILL,
        DONE
    } state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Assembles incoming bytes little-endian into one instruction word.
// Flags the byte that completes the word so the FSM can leave RECV on the same edge.
module imem_loader_word_packer
    import imem_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clear,
    input  logic                          load,
    input  logic [7:0]                    data,
    output logic [8*BYTES_PER_WORD-1:0]   word,
    output logic                          word_ready
);

    logic [1:0] bcnt;

    assign word_ready = load && (bcnt == 2'(BYTES_PER_WORD - 1));

    // Clearing zeroes the word as well, so the same register can feed zeros during fill.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word <= '0;
            bcnt <= '0;
        end else if (clear) begin
            word <= '0;
            bcnt <= '0;
        end else if (load) begin
            word[{bcnt, 3'b000} +: 8] <= data;
            bcnt                      <= bcnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a byte-serial program into the instruction memory, zero-filling the tail,
// while holding the processor in reset for the duration of the load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [6:0]    len,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [N-1:0]  wr_data,
    output logic          busy,
    output logic          done,
    output logic          cpu_hold
);

    localparam logic [AW:0] DEPTH_IDX = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LAST_IDX  = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0] ONE       = (AW + 1)'(1);

    state_t      state;
    logic [AW:0] idx;
    logic [AW:0] len_q;
    logic [AW:0] len_clamped;
    logic        accept;
    logic        pack_clear;
    logic        word_ready;
    logic [N-1:0] word;

    assign len_clamped = (len > DEPTH_IDX) ? DEPTH_IDX : len;
    assign accept      = rx_valid && rx_ready;
    assign pack_clear  = ((state == IDLE) && start) || (state == WRITE);
    assign wr_addr     = idx[AW-1:0];
    assign wr_data     = word;
    assign cpu_hold    = busy;

    imem_loader_word_packer packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (pack_clear),
        .load       (accept),
        .data       (rx_data),
        .word       (word),
        .word_ready (word_ready)
    );

    // Outputs are assigned alongside each state change so they are valid in the new state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            idx      <= '0;
            len_q    <= '0;
            rx_ready <= 1'b0;
            wr_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        len_q <= len_clamped;
                        busy  <= 1'b1;
                        if (len_clamped != '0) begin
                            state    <= RECV;
                            rx_ready <= 1'b1;
                        end else begin
                            state <= FILL;
                            wr_en <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (word_ready) begin
                        state    <= WRITE;
                        rx_ready <= 1'b0;
                        wr_en    <= 1'b1;
                    end
                end
                WRITE: begin
                    idx <= idx + ONE;
                    if (idx == len_q - ONE) begin
                        if (len_q < DEPTH_IDX) begin
                            state <= FILL;
                        end else begin
                            state <= DONE;
                            wr_en <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        state    <= RECV;
                        wr_en    <= 1'b0;
                        rx_ready <= 1'b1;
                    end
                end
                FILL: begin
                    idx <= idx + ONE;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                        wr_en <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    rx_ready <= 1'b0;
                    wr_en    <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a negedge monitor models the instruction memory
// and records write order, done width and handshake overlap for each load.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [6:0]  len;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        cpu_hold;

    logic [31:0] mem [0:63];
    logic [7:0]  prog [0:255];
    int writes, orderErr, nextAddr, overlap, doneCycles, readyCycles, holdErr;
    int bpos, junkAccepted, cycles, badWords, nonZero, guard;
    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .len      (len),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .cpu_hold (cpu_hold)
    );

    // Memory model and protocol observers, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            mem[wr_addr] = wr_data;
            writes++;
            if (int'(wr_addr) != nextAddr) orderErr++;
            nextAddr++;
            if (rx_ready === 1'b1) overlap++;
        end
        if (done === 1'b1) doneCycles++;
        if (rx_ready === 1'b1) readyCycles++;
        if (busy !== cpu_hold) holdErr++;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clearStats();
        writes       = 0;
        orderErr     = 0;
        nextAddr     = 0;
        overlap      = 0;
        doneCycles   = 0;
        readyCycles  = 0;
        holdErr      = 0;
        bpos         = 0;
        junkAccepted = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'hDEADBEEF;
    endtask

    task automatic countBadWords();
        badWords = 0;
        for (int k = 0; k < 64; k++)
            if (mem[k] !== {prog[4*k+3], prog[4*k+2], prog[4*k+1], prog[4*k]}) badWords++;
    endtask

    // cycles counts the start cycle as 1 and ends on the cycle where done is seen.
    task automatic applyStimulus(input logic [6:0] lenArg, input int nbytes, input bit toggle,
                                 input bit junk, input bit poke, input int limit);
        clearStats();
        len      = lenArg;
        start    = 1'b1;
        rx_valid = 1'b0;
        tick();
        start  = 1'b0;
        cycles = 2;
        while (done !== 1'b1 && cycles < limit) begin
            if (bpos < nbytes) begin
                rx_valid = toggle ? (cycles % 2 == 1) : 1'b1;
                rx_data  = prog[bpos];
            end else begin
                rx_valid = junk;
                rx_data  = 8'hFF;
            end
            start = poke && (cycles == 100);
            len   = (poke && cycles == 100) ? 7'd1 : lenArg;
            if (rx_valid && rx_ready === 1'b1) begin
                if (bpos < nbytes) bpos++;
                else junkAccepted++;
            end
            tick();
            cycles++;
        end
        rx_valid = 1'b0;
        start    = 1'b0;
        checkOutput("done_seen", 32'(done), 32'd1);
        tick();
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset held with start and rx_valid asserted must keep everything quiet.
        clearStats();
        reset_n  = 1'b0;
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        len      = 7'd3;
        repeat (3) tick();
        checkOutput("rst_rx_ready", 32'(rx_ready), 32'd0);
        checkOutput("rst_wr_en",    32'(wr_en),    32'd0);
        checkOutput("rst_wr_addr",  32'(wr_addr),  32'd0);
        checkOutput("rst_wr_data",  wr_data,       32'd0);
        checkOutput("rst_busy",     32'(busy),     32'd0);
        checkOutput("rst_done",     32'(done),     32'd0);
        checkOutput("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        checkOutput("rst_writes",   writes,        32'd0);
        start    = 1'b0;
        rx_valid = 1'b0;
        reset_n  = 1'b1;
        repeat (2) tick();
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Two words back-to-back, then 62 zero-fill writes.
        {prog[0], prog[1], prog[2], prog[3]} = {8'h37, 8'h00, 8'h01, 8'hCB};
        {prog[4], prog[5], prog[6], prog[7]} = {8'h00, 8'h03, 8'h04, 8'h8B};
        applyStimulus(7'd2, 8, 1'b0, 1'b0, 1'b0, 200);
        checkOutput("l2_cycles",  cycles,     32'd74);
        checkOutput("l2_word0",   mem[0],     32'hCB010037);
        checkOutput("l2_word1",   mem[1],     32'h8B040300);
        checkOutput("l2_word2",   mem[2],     32'h0);
        checkOutput("l2_word63",  mem[63],    32'h0);
        checkOutput("l2_writes",  writes,     32'd64);
        checkOutput("l2_order",   orderErr,   32'd0);
        checkOutput("l2_done_w",  doneCycles, 32'd1);
        checkOutput("l2_hold",    holdErr,    32'd0);

        // One word with rx_valid on only every other cycle.
        {prog[0], prog[1], prog[2], prog[3]} = {8'h93, 8'h00, 8'h10, 8'h00};
        applyStimulus(7'd1, 4, 1'b1, 1'b0, 1'b0, 200);
        checkOutput("tg_word0",   mem[0],  32'h00100093);
        checkOutput("tg_word1",   mem[1],  32'h0);
        checkOutput("tg_bytes",   bpos,    32'd4);
        checkOutput("tg_overlap", overlap, 32'd0);
        checkOutput("tg_writes",  writes,  32'd64);
        checkOutput("tg_cycles",  cycles,  32'd74);

        // Empty program: pure zero fill, no byte ever accepted.
        applyStimulus(7'd0, 0, 1'b0, 1'b1, 1'b0, 200);
        nonZero = 0;
        for (int k = 0; k < 64; k++) if (mem[k] !== 32'h0) nonZero++;
        checkOutput("l0_cycles",  cycles,       32'd66);
        checkOutput("l0_ready",   readyCycles,  32'd0);
        checkOutput("l0_junk",    junkAccepted, 32'd0);
        checkOutput("l0_writes",  writes,       32'd64);
        checkOutput("l0_nonzero", nonZero,      32'd0);
        checkOutput("l0_order",   orderErr,     32'd0);

        // Full memory, with a stray start mid-load and rx_valid held after the last byte.
        for (int i = 0; i < 256; i++) prog[i] = 8'(i * 7 + 3);
        applyStimulus(7'd64, 256, 1'b0, 1'b1, 1'b1, 1000);
        countBadWords();
        checkOutput("l64_cycles", cycles,       32'd322);
        checkOutput("l64_writes", writes,       32'd64);
        checkOutput("l64_order",  orderErr,     32'd0);
        checkOutput("l64_done_w", doneCycles,   32'd1);
        checkOutput("l64_junk",   junkAccepted, 32'd0);
        checkOutput("l64_words",  badWords,     32'd0);
        checkOutput("l64_word63", mem[63],      {prog[255], prog[254], prog[253], prog[252]});
        repeat (3) tick();
        checkOutput("l64_no_restart", 32'(busy), 32'd0);

        // Oversized length behaves as a full load.
        applyStimulus(7'd100, 256, 1'b0, 1'b0, 1'b0, 1000);
        countBadWords();
        checkOutput("clamp_cycles", cycles,   32'd322);
        checkOutput("clamp_writes", writes,   32'd64);
        checkOutput("clamp_words",  badWords, 32'd0);

        // Reset dropped two bytes into word 3, then a fresh single-word load.
        for (int i = 0; i < 14; i++) prog[i] = 8'(8'hC0 + i);
        clearStats();
        len   = 7'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (bpos < 14 && guard < 100) begin
            rx_valid = 1'b1;
            rx_data  = prog[bpos];
            if (rx_ready === 1'b1) bpos++;
            tick();
            guard++;
        end
        rx_valid = 1'b1;
        checkOutput("mid_bytes",  bpos,   32'd14);
        checkOutput("mid_writes", writes, 32'd3);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_busy",     32'(busy),     32'd0);
        checkOutput("mid_rx_ready", 32'(rx_ready), 32'd0);
        checkOutput("mid_wr_en",    32'(wr_en),    32'd0);
        checkOutput("mid_cpu_hold", 32'(cpu_hold), 32'd0);
        repeat (2) tick();
        checkOutput("mid_no_write", writes, 32'd3);
        reset_n  = 1'b1;
        rx_valid = 1'b0;
        tick();
        {prog[0], prog[1], prog[2], prog[3]} = {8'h11, 8'h22, 8'h33, 8'h44};
        applyStimulus(7'd1, 4, 1'b0, 1'b0, 1'b0, 200);
        checkOutput("re_word0",  mem[0],   32'h44332211);
        checkOutput("re_writes", writes,   32'd64);
        checkOutput("re_cycles", cycles,   32'd70);
        checkOutput("re_order",  orderErr, 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
